// File: rtl/prob2_sched_pkg.sv
// +--------------------------------------------------------------------+
// | prob2states : shared types for the Problem 2 detector and its     |
// | round-robin frame scheduler.                  Rev 1.1             |
// +--------------------------------------------------------------------+
`default_nettype none

package prob2states;

  // Detector state encodings, unchanged from the original detector.
  typedef enum logic [2:0] {
    S1 = 3'd0,
    S2 = 3'd1,
    S3 = 3'd2,
    S4 = 3'd3,
    S5 = 3'd4
  } det_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int SCHED_W_DEFAULT = 8;

  // Requester index to serve, given the request vector and the last-served index.
  function automatic logic arb_pick(input logic [1:0] req, input logic last_id);
    logic pick;
    if (req == 2'b11) begin
      pick = ~last_id;
    end else begin
      pick = req[1];
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prob2_sched_if.sv
// +--------------------------------------------------------------------+
// | prob2_sched_if : requester/detector-side bundle of prob2_sched.   |
// |                                               Rev 1.1             |
// +--------------------------------------------------------------------+
`default_nettype none

interface prob2_sched_if
  import prob2states::*;
#(
  parameter int W  = SCHED_W_DEFAULT,
  parameter int CW = $clog2(W + 1)
);

  logic [1:0]    req;
  logic [W-1:0]  data0;
  logic [W-1:0]  data1;
  logic [1:0]    gnt;
  logic          X;
  logic          Z1;
  logic          Z2;
  logic          busy;
  logic          done;
  logic          done_id;
  logic [CW-1:0] z1_cnt;
  logic [CW-1:0] z2_cnt;

  modport slave (
    input  req, data0, data1, Z1, Z2,
    output gnt, X, busy, done, done_id, z1_cnt, z2_cnt
  );

  modport master (
    output req, data0, data1, Z1, Z2,
    input  gnt, X, busy, done, done_id, z1_cnt, z2_cnt
  );

endinterface

`default_nettype wire

// File: rtl/prob2_sched_ser.sv
// +--------------------------------------------------------------------+
// | prob2_ser : frame shift register with bit index and last-bit flag.|
// |                                               Rev 1.1             |
// +--------------------------------------------------------------------+
`default_nettype none

module prob2_ser #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:1] i_load_data,
  output logic         o_next_bit,
  output logic         o_first,
  output logic         o_last
);

  localparam int IW = $clog2(W);

  // Bit 0 of the word goes straight to X at acceptance, so only the
  // upper bits are stored; sr_q[0] is always the bit for the next cycle.
  logic [W-2:0] sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (i_load) begin
      sr_d  = i_load_data;
      idx_d = '0;
    end else if (i_shift) begin
      sr_d  = sr_q >> 1;
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  assign o_next_bit = sr_q[0];
  assign o_first    = (idx_q == '0);
  assign o_last     = (idx_q == IW'(W - 1));

endmodule

`default_nettype wire

// File: rtl/prob2_sched.sv
// +--------------------------------------------------------------------+
// | prob2_sched : round-robin scheduler/serializer sharing the        |
// | Problem 2 detector between two requesters.    Rev 1.1             |
// +--------------------------------------------------------------------+
`default_nettype none

module prob2_sched
  import prob2states::*;
#(
  parameter int W  = SCHED_W_DEFAULT,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         reset,
  prob2_sched_if.slave bus
);

  sched_state_t  state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          x_q, x_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          id_q, id_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] z1_q, z1_d;
  logic [CW-1:0] z2_q, z2_d;

  logic          sel_id;
  logic [W-1:0]  sel_data;
  logic          ser_load;
  logic          ser_shift;
  logic          ser_next_bit;
  logic          ser_first;
  logic          ser_last;
  logic [CW-1:0] z1_inc;
  logic [CW-1:0] z2_inc;

  assign sel_id   = arb_pick(bus.req, ptr_q);
  assign sel_data = sel_id ? bus.data1 : bus.data0;
  assign z1_inc   = {{(CW-1){1'b0}}, bus.Z1};
  assign z2_inc   = {{(CW-1){1'b0}}, bus.Z2};

  prob2_ser #(
    .W (W)
  ) u_ser (
    .clk         (clk),
    .reset       (reset),
    .i_load      (ser_load),
    .i_shift     (ser_shift),
    .i_load_data (sel_data[W-1:1]),
    .o_next_bit  (ser_next_bit),
    .o_first     (ser_first),
    .o_last      (ser_last)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = 2'b00;
    x_d       = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    id_d      = id_q;
    ptr_d     = ptr_q;
    z1_d      = z1_q;
    z2_d      = z2_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d  = SHIFT;
          gnt_d    = sel_id ? 2'b10 : 2'b01;
          x_d      = sel_data[0];
          busy_d   = 1'b1;
          id_d     = sel_id;
          ptr_d    = sel_id;
          z1_d     = '0;
          z2_d     = '0;
          ser_load = 1'b1;
        end
      end

      SHIFT: begin
        // Z seen in cycle 0 belongs to the idle zero before the frame.
        if (!ser_first) begin
          z1_d = z1_q + z1_inc;
          z2_d = z2_q + z2_inc;
        end
        if (ser_last) begin
          state_d = DRAIN;
        end else begin
          x_d       = ser_next_bit;
          ser_shift = 1'b1;
        end
      end

      DRAIN: begin
        z1_d    = z1_q + z1_inc;
        z2_d    = z2_q + z2_inc;
        done_d  = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b1;
      z1_q    <= '0;
      z2_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      z1_q    <= z1_d;
      z2_q    <= z2_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.X       = x_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = id_q;
  assign bus.z1_cnt  = z1_q;
  assign bus.z2_cnt  = z2_q;

endmodule

`default_nettype wire

// File: tb/tb_prob2_sched.sv
// +--------------------------------------------------------------------+
// | tb_prob2_sched : bench for prob2_sched driving a Problem 2        |
// | detector model.                               Rev 1.1             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_prob2_sched;
  import prob2states::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  prob2_sched_if #(.W(W), .CW(CW)) bus ();

  prob2_sched #(.W(W), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Moore detector: Z1 in S2, Z2 in S3; no reset, powers up in S1.
  det_state_t det_q = S1;

  always @(posedge clk) begin
    case (det_q)
      S1:      det_q <= (bus.X === 1'b1) ? S2 : S1;
      S2:      det_q <= (bus.X === 1'b1) ? S4 : S3;
      S3:      det_q <= (bus.X === 1'b1) ? S2 : S5;
      S4:      det_q <= (bus.X === 1'b1) ? S4 : S3;
      S5:      det_q <= (bus.X === 1'b1) ? S4 : S5;
      default: det_q <= S1;
    endcase
  end

  assign bus.Z1 = (det_q == S2);
  assign bus.Z2 = (det_q == S3);

  typedef struct {
    int id;
    int z1;
    int z2;
  } exp_t;

  typedef struct {
    logic         rst_before;
    logic [1:0]   req;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [1:0]   gnt;
    logic         id;
    int           z1;
    int           z2;
    int           pulse;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input int z1, input int z2);
    exp_t e;
    e.id = id;
    e.z1 = z1;
    e.z2 = z2;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(input int bound, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.gnt == 2'b00 && lat < bound);
    if (bus.gnt == 2'b00) check("gnt_timeout", 0, 1);
  endtask

  // One complete frame from an idle DUT, checking X bit by bit.
  task automatic run_frame(input vec_t v);
    int           lat;
    logic [W-1:0] word;
    word = v.id ? v.d1 : v.d0;
    push_exp(int'(v.id), v.z1, v.z2);
    bus.data0 = v.d0;
    bus.data1 = v.d1;
    bus.req   = v.req;
    wait_gnt(20, lat);
    check("gnt_latency", lat, 1);
    check("gnt", int'(bus.gnt), int'(v.gnt));
    check("busy_at_gnt", int'(bus.busy), 1);
    check("cnt_clear", int'(bus.z1_cnt) + int'(bus.z2_cnt), 0);
    for (int i = 0; i < W; i++) begin
      check("x_bit", int'(bus.X), int'(word[i]));
      bus.req = (i == v.pulse) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    check("x_drain", int'(bus.X), 0);
    check("done_early", int'(bus.done), 0);
    @(negedge clk);
    check("done_timing", int'(bus.done), 1);
    check("x_done", int'(bus.X), 0);
    check("busy_done", int'(bus.busy), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_done", int'(bus.done), 0);
      check("idle_gnt", int'(bus.gnt), 0);
      check("idle_busy", int'(bus.busy), 0);
      check("idle_x", int'(bus.X), 0);
    end
  endtask

  // Scoreboard: every done pops the oldest expected frame result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_id", int'(bus.done_id), e.id);
          check("z1_cnt", int'(bus.z1_cnt), e.z1);
          check("z2_cnt", int'(bus.z2_cnt), e.z2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   n;
    vec_t v;

    vecs[0] = '{1'b0, 2'b01, 8'h02, 8'h00, 2'b01, 1'b0, 1, 1, -1};
    vecs[1] = '{1'b0, 2'b01, 8'h22, 8'h00, 2'b01, 1'b0, 0, 2, -1};
    vecs[2] = '{1'b0, 2'b01, 8'hFF, 8'h00, 2'b01, 1'b0, 0, 0, -1};
    vecs[3] = '{1'b0, 2'b10, 8'h00, 8'h80, 2'b10, 1'b1, 0, 0, -1};
    vecs[4] = '{1'b0, 2'b11, 8'h05, 8'h01, 2'b01, 1'b0, 1, 2, -1};
    vecs[5] = '{1'b0, 2'b11, 8'h01, 8'h0D, 2'b10, 1'b1, 1, 2, -1};
    vecs[6] = '{1'b0, 2'b01, 8'h03, 8'h00, 2'b01, 1'b0, 0, 1, 3};
    vecs[7] = '{1'b0, 2'b01, 8'h01, 8'h00, 2'b01, 1'b0, 0, 1, -1};
    vecs[8] = '{1'b1, 2'b11, 8'h02, 8'h05, 2'b01, 1'b0, 0, 1, -1};

    bus.req   = 2'b00;
    bus.data0 = '0;
    bus.data1 = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_x", int'(bus.X), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_done_id", int'(bus.done_id), 0);
    check("rst_z1", int'(bus.z1_cnt), 0);
    check("rst_z2", int'(bus.z2_cnt), 0);
    reset = 1'b0;

    foreach (vecs[j]) begin
      if (vecs[j].rst_before) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
      end
      run_frame(vecs[j]);
    end

    // Both requesters held: grants alternate starting with requester 1.
    push_exp(1, 0, 1);
    push_exp(0, 1, 2);
    push_exp(1, 0, 1);
    push_exp(0, 1, 2);
    bus.data0 = 8'h05;
    bus.data1 = 8'h01;
    bus.req   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(30, lat);
      check("alt_gnt", int'(bus.gnt), (k % 2 == 0) ? 2 : 1);
      if (k > 0) check("alt_period", lat, W + 3);
      if (k == 3) bus.req = 2'b00;
    end
    repeat (W + 6) @(negedge clk);
    check("alt_sb_empty", exp_q.size(), 0);

    // Reset in SHIFT cycle 4 abandons the frame.
    bus.data1 = 8'h25;
    bus.req   = 2'b10;
    wait_gnt(20, lat);
    check("abort_gnt", int'(bus.gnt), 2);
    bus.req = 2'b00;
    repeat (4) @(negedge clk);
    check("abort_mid_z1", int'(bus.z1_cnt), 1);
    check("abort_mid_z2", int'(bus.z2_cnt), 1);
    check("abort_mid_id", int'(bus.done_id), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_x", int'(bus.X), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_gnt_lo", int'(bus.gnt), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_z1", int'(bus.z1_cnt), 0);
    check("abort_z2", int'(bus.z2_cnt), 0);
    check("abort_id", int'(bus.done_id), 0);
    reset = 1'b0;
    n = done_cnt;
    repeat (W + 4) @(negedge clk);
    check("abort_no_done", done_cnt, n);
    v = '{1'b0, 2'b10, 8'h00, 8'h0D, 2'b10, 1'b1, 1, 2, -1};
    run_frame(v);

    repeat (4) @(negedge clk);
    check("final_sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prob2_sched.md
# prob2_sched

Round-robin scheduler and serializer that shares the single-bit Problem 2 sequence detector between two requesters. Each requester hands over a W-bit word. The scheduler shifts the word LSB-first onto the detector's X input, then counts the Z1 and Z2 pulses attributable to that frame. It returns both counts with a one-cycle done strobe. The block sits between the requester logic and the detector instance, and it is the only driver of the detector's X.

## Interface
- W, 8: frame length in bits, 2..16.
- CW, $clog2(W+1): width of each count output.
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- req  in  2  req[i] high requests a frame from requester i; held until gnt[i].
- data0  in  W  frame word of requester 0, sampled at acceptance edge.
- data1  in  W  frame word of requester 1, sampled at acceptance edge.
- gnt  out  2  one-hot, one-cycle acceptance pulse.
- X  out  1  registered serial bit to detector X.
- Z1  in  1  detector Z1 output.
- Z2  in  1  detector Z2 output.
- busy  out  1  high from acceptance through the DONE state.
- done  out  1  one-cycle strobe; the id and count outputs are valid in that cycle.
- done_id  out  1  requester index of the completed frame.
- z1_cnt  out  CW  Z1 pulses counted in the frame.
- z2_cnt  out  CW  Z2 pulses counted in the frame.

## Operation
- States: IDLE, SHIFT, DRAIN, DONE.
- IDLE: X=0.
  - If any req bit is high at an edge, select the requester, latch its data, clear both counters and record the id.
  - Move to SHIFT with bit index 0, driving X=data[0] from the same edge.
- Arbitration: a 1-bit pointer holds the last-served requester.
  - Single request: grant it.
  - Both requesting: grant the one not last served.
  - After reset the pointer favours requester 0.
- SHIFT, W cycles: cycle i drives X=data[i]. In cycle i≥1, increment z1_cnt if Z1=1 and z2_cnt if Z2=1. After cycle W-1, move to DRAIN.
- DRAIN, 1 cycle: X=0; sample Z1/Z2 for bit W-1.
- DONE, 1 cycle: X=0; done=1; done_id and counts held stable; then IDLE.
- Counts never exceed W, so no saturation logic is needed. Z1 and Z2 are counted independently even if both are high.
- The detector has no reset or enable and is clocked every cycle. X=0 on every non-SHIFT cycle, including reset, and that is the defined idle line value.
  - Detector state carries across frames and is never flushed.
  - Pulses caused by idle zeros are not counted.
- A req dropped before its grant is ignored. A new req does not disturb an in-flight frame.
- reset asserted in any state, mid-frame included, at the next edge:
  - state IDLE, X=0, gnt=0, busy=0, done=0;
  - counts 0, done_id 0, pointer reset;
  - the frame is abandoned with no done.

## Timing
- Reset values: gnt=0, X=0, busy=0, done=0, done_id=0, z1_cnt=0, z2_cnt=0.
- All outputs are registered; no combinational path from req, Z1 or Z2 to any output.
- The acceptance edge is the end of the IDLE cycle with req seen. The cycle after it is SHIFT cycle 0, in which gnt and busy are both high. gnt is high only in that cycle.
- Detector sampling: the bit driven in cycle k is sampled by the detector at edge k+1, and its Z appears in cycle k+1.
- done rises W+1 cycles after SHIFT cycle 0.
- Minimum frame-to-frame period is W+3 cycles: SHIFT W, DRAIN 1, DONE 1, IDLE 1. There is no acceptance from DONE.

## Structure
- Package prob2states (shared, existing): add `sched_state_t` enum (IDLE, SHIFT, DRAIN, DONE) and constant `SCHED_W_DEFAULT=8`. The detector state encodings stay as they are.
- Sub-module prob2_ser: W-bit load/shift register with a bit-index counter and a last-bit flag. The scheduler owns the FSM, the arbiter pointer and the counters.
- The bench instantiates prob2_sched with the detector wired X to X and Z1/Z2 back.

## Test plan
- Reset for 3 cycles, then req=01, data0=8'b00000010 → gnt=01 in SHIFT cycle 0. Detector starts in S1 (idle zeros). Result: done 9 cycles later, done_id=0, z1_cnt=1, z2_cnt=1; detector ends in S5.
- Continuing: req=01, data0=8'b00100010 → z1_cnt=0, z2_cnt=2, done_id=0.
- req=11 held continuously → grants alternate 1,0,1,…; frames accepted every 11 cycles; each done_id matches its preceding gnt.
- Reset asserted in SHIFT cycle 4 → next cycle X=0, busy=0, counts 0, no done; the next req=10 is granted to requester 1 in the normal accept-to-grant timing.
- req pulsed for one cycle while busy → ignored: no gnt and no extra done after the current frame.
- data0=8'hFF with the detector in S5 → z1_cnt=0, z2_cnt=0; X matches the data bits LSB-first in cycles 0..7 and is 0 otherwise.
